// File: rtl/stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// stack_ctrl_if
//   Bundles the request/response handshake from the control unit and the
//   data-memory port driven by stack_ctrl.
//
//   Request side : req_push, req_pop, push_data -> controller
//                  busy, done, err, err_code, pop_data, sp <- controller
//   Memory side  : mem_addr, mem_wdata, mem_we, mem_re <- controller
//                  mem_rdata, mem_ready -> controller
//
//   Modports:
//     slave  - the stack controller itself
//     master - the environment (control unit + memory) around it
// -----------------------------------------------------------------------------
interface stack_ctrl_if;
    logic        req_push;
    logic        req_pop;
    logic [15:0] push_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] pop_data;
    logic [15:0] sp;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  req_push, req_pop, push_data, mem_rdata, mem_ready,
        output busy, done, err, err_code, pop_data, sp,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_push, req_pop, push_data, mem_rdata, mem_ready,
        input  busy, done, err, err_code, pop_data, sp,
               mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface : stack_ctrl_if

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
//   Stack-operation sequencer for the 16-bit processor. Owns the stack pointer
//   and performs PUSH/POP accesses on the data memory for the control unit,
//   with overflow/underflow checking and a bounded wait on mem_ready.
//
//   The stack is empty-descending: SP points at the next free slot. A push
//   writes mem[SP] and then decrements SP; a pop increments SP and reads the
//   slot it now points to.
//
//   Ports:
//     i_clk   - clock, rising edge
//     i_rst   - asynchronous, active-high reset
//     if_stk  - stack_ctrl_if.slave: request handshake, status and memory port
//
//   Parameters:
//     STACK_TOP   - SP reset value; stack is empty when SP == STACK_TOP
//     STACK_LIMIT - lowest writable address; a push with SP below it overflows
//     WAIT_MAX    - cycles an access may wait for mem_ready (>= 1)
// -----------------------------------------------------------------------------
module stack_ctrl #(
    parameter logic [15:0] STACK_TOP   = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00,
    parameter int unsigned WAIT_MAX    = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    stack_ctrl_if.slave  if_stk
);

    // Wait counter counts 0 .. WAIT_MAX-1 inside an access state.
    localparam int unsigned     WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP,
        S_FAIL
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [15:0]       r_sp,       w_sp_nxt;
    logic [15:0]       r_wdata,    w_wdata_nxt;
    logic [15:0]       r_pop_data, w_pop_data_nxt;
    logic [1:0]        r_err_code, w_err_code_nxt;
    logic [WAIT_W-1:0] r_wait,     w_wait_nxt;

    logic [15:0]       w_sp_inc;
    logic              w_busy;
    logic              w_done;
    logic              w_err;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [15:0]       w_mem_addr;
    logic [15:0]       w_mem_wdata;

    // Slot a pop reads; 16-bit wrap is intentional.
    assign w_sp_inc = r_sp + 16'd1;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_sp_nxt       = r_sp;
        w_wdata_nxt    = r_wdata;
        w_pop_data_nxt = r_pop_data;
        w_err_code_nxt = r_err_code;
        w_wait_nxt     = r_wait;

        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = 16'h0000;
        w_mem_wdata = 16'h0000;

        unique case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_wait_nxt = '0;
                // Push wins a tie; the simultaneous pop is simply not accepted.
                if (if_stk.req_push) begin
                    if (r_sp < STACK_LIMIT) begin
                        w_err_code_nxt = ERR_OVF;
                        w_state_nxt    = S_FAIL;
                    end else begin
                        w_err_code_nxt = ERR_NONE;
                        w_wdata_nxt    = if_stk.push_data;
                        w_state_nxt    = S_WRITE;
                    end
                end else if (if_stk.req_pop) begin
                    if (r_sp == STACK_TOP) begin
                        w_err_code_nxt = ERR_UNF;
                        w_state_nxt    = S_FAIL;
                    end else begin
                        w_err_code_nxt = ERR_NONE;
                        w_state_nxt    = S_READ;
                    end
                end
            end

            S_WRITE: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_sp;
                w_mem_wdata = r_wdata;
                // A ready on the last allowed cycle still completes the access.
                if (if_stk.mem_ready) begin
                    w_sp_nxt    = r_sp - 16'd1;
                    w_state_nxt = S_RESP;
                end else if (r_wait == WAIT_LAST) begin
                    w_err_code_nxt = ERR_TMO;
                    w_state_nxt    = S_FAIL;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end

            S_READ: begin
                w_mem_re   = 1'b1;
                w_mem_addr = w_sp_inc;
                if (if_stk.mem_ready) begin
                    w_pop_data_nxt = if_stk.mem_rdata;
                    w_sp_nxt       = w_sp_inc;
                    w_state_nxt    = S_RESP;
                end else if (r_wait == WAIT_LAST) begin
                    w_err_code_nxt = ERR_TMO;
                    w_state_nxt    = S_FAIL;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end

            S_RESP: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            S_FAIL: begin
                w_err       = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: non-blocking assignments so every register samples the values
        // computed from the pre-edge state, independent of statement order.
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sp       <= STACK_TOP;
            r_wdata    <= 16'h0000;
            r_pop_data <= 16'h0000;
            r_err_code <= ERR_NONE;
            r_wait     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sp       <= w_sp_nxt;
            r_wdata    <= w_wdata_nxt;
            r_pop_data <= w_pop_data_nxt;
            r_err_code <= w_err_code_nxt;
            r_wait     <= w_wait_nxt;
        end
    end

    // Strobes and pulses decode straight from the state register, so an
    // asynchronous reset drops them immediately.
    assign if_stk.busy      = w_busy;
    assign if_stk.done      = w_done;
    assign if_stk.err       = w_err;
    assign if_stk.err_code  = r_err_code;
    assign if_stk.pop_data  = r_pop_data;
    assign if_stk.sp        = r_sp;
    assign if_stk.mem_addr  = w_mem_addr;
    assign if_stk.mem_wdata = w_mem_wdata;
    assign if_stk.mem_we    = w_mem_we;
    assign if_stk.mem_re    = w_mem_re;

endmodule : stack_ctrl

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
//   Self-checking bench for stack_ctrl. A behavioural memory answers the
//   access strobes after a programmable number of stall cycles; a queue-based
//   stack model predicts the outcome, latency, SP and pop data of each request.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;

    localparam logic [15:0] STACK_TOP   = 16'hFFFF;
    localparam logic [15:0] STACK_LIMIT = 16'hFF00;
    localparam int          WAIT_MAX    = 8;
    localparam int          DEPTH       = int'(STACK_TOP) - int'(STACK_LIMIT) + 1;

    typedef enum int {K_DONE, K_OVF, K_UNF, K_TMO, K_HANG} kind_e;

    typedef struct {
        bit          p;
        bit          q;
        logic [15:0] d;
        int          lat;
        kind_e       ek;
        logic [15:0] sp;
        logic [1:0]  code;
        logic [15:0] pd;
    } vec_t;

    logic clk = 1'b1;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    stack_ctrl_if bus();

    stack_ctrl #(
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT),
        .WAIT_MAX    (WAIT_MAX)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .if_stk (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural memory ----------------
    int          mem_lat = 0;
    int          acc_cnt = 0;
    bit          both_hi = 1'b0;
    logic [15:0] tb_mem [0:65535];

    always @(negedge clk) begin
        if (bus.mem_we && bus.mem_re) both_hi = 1'b1;
        if (bus.mem_we || bus.mem_re) begin
            bus.mem_ready = (acc_cnt >= mem_lat);
            bus.mem_rdata = tb_mem[bus.mem_addr];
            acc_cnt++;
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 16'h0000;
            acc_cnt = 0;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_ready) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // ---------------- stack model ----------------
    logic [15:0] model [$];
    logic [15:0] last_pop = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic do_reset();
        bus.req_push  = 1'b0;
        bus.req_pop   = 1'b0;
        bus.push_data = 16'h0000;
        mem_lat       = 0;
        rst = 1'b1;
        #1;
        check("rst_sp",       bus.sp, STACK_TOP);
        check("rst_busy",     bus.busy, 0);
        check("rst_done_err", {bus.done, bus.err}, 0);
        check("rst_strobes",  {bus.mem_we, bus.mem_re}, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_pop_data", bus.pop_data, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        last_pop = 16'h0000;
    endtask

    // Issues one request from IDLE and follows it to its done/err pulse.
    // Starts and ends just after a falling edge with the controller idle.
    task automatic run_op(input bit p, input bit q, input logic [15:0] d, input int lat,
                          input bit noise, output kind_e ok, output logic [15:0] osp,
                          output logic [1:0] ocode, output logic [15:0] opd);
        int          n;
        int          k;
        int          ecyc;
        bit          fin;
        kind_e       ek;
        logic [1:0]  ecode;
        logic [15:0] sp0;

        n   = model.size();
        sp0 = STACK_TOP - 16'(n);
        if (p) ek = (n >= DEPTH) ? K_OVF : ((lat >= WAIT_MAX) ? K_TMO : K_DONE);
        else   ek = (n == 0)     ? K_UNF : ((lat >= WAIT_MAX) ? K_TMO : K_DONE);
        case (ek)
            K_DONE:  begin ecyc = 2 + lat;      ecode = 2'b00; end
            K_OVF:   begin ecyc = 1;            ecode = 2'b01; end
            K_UNF:   begin ecyc = 1;            ecode = 2'b10; end
            default: begin ecyc = WAIT_MAX + 1; ecode = 2'b11; end
        endcase

        bus.req_push  = p;
        bus.req_pop   = q;
        bus.push_data = d;
        mem_lat       = lat;
        k   = 0;
        fin = 1'b0;
        while (!fin && k < 64) begin
            @(negedge clk);
            k++;
            bus.req_push = 1'b0;
            bus.req_pop  = 1'b0;
            if (k == 1) begin
                check("busy_after_accept", bus.busy, 1);
                if (ek == K_DONE || ek == K_TMO) begin
                    check("strobes", {bus.mem_we, bus.mem_re}, p ? 2'b10 : 2'b01);
                    check("mem_addr", bus.mem_addr, p ? sp0 : sp0 + 16'd1);
                    if (p) check("mem_wdata", bus.mem_wdata, d);
                end else begin
                    check("no_strobe_on_reject", {bus.mem_we, bus.mem_re}, 0);
                end
            end
            if (bus.done || bus.err) begin
                fin = 1'b1;
            end else if (noise && bus.busy) begin
                // Requests while busy must be ignored.
                bus.req_push  = 1'($urandom_range(0, 1));
                bus.req_pop   = 1'($urandom_range(0, 1));
                bus.push_data = 16'($urandom);
            end
        end

        check("latency", k, ecyc);
        if (!fin)          ok = K_HANG;
        else if (bus.done) ok = K_DONE;
        else begin
            case (bus.err_code)
                2'b01:   ok = K_OVF;
                2'b10:   ok = K_UNF;
                2'b11:   ok = K_TMO;
                default: ok = K_HANG;
            endcase
        end
        check("done_flag", bus.done, ek == K_DONE);
        check("err_flag",  bus.err,  ek != K_DONE);
        check("err_code",  bus.err_code, ecode);
        if (ek != K_DONE) check("strobes_in_fail", {bus.mem_we, bus.mem_re}, 0);

        if (ek == K_DONE) begin
            if (p) model.push_back(d);
            else   last_pop = model.pop_back();
        end
        check("sp", bus.sp, STACK_TOP - 16'(model.size()));
        check("pop_data", bus.pop_data, last_pop);
        osp   = bus.sp;
        ocode = bus.err_code;
        opd   = bus.pop_data;

        if (fin) begin
            @(negedge clk);
            bus.req_push = 1'b0;
            bus.req_pop  = 1'b0;
            check("pulse_1cycle", {bus.done, bus.err}, 0);
            check("idle_after",   bus.busy, 0);
            check("err_code_hold", bus.err_code, ecode);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [10];
        kind_e       ok;
        logic [15:0] osp;
        logic [1:0]  ocode;
        logic [15:0] opd;

        vecs[0] = '{1'b1, 1'b0, 16'h1234, 0,            K_DONE, 16'hFFFE, 2'b00, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 0,            K_DONE, 16'hFFFF, 2'b00, 16'h1234};
        vecs[2] = '{1'b0, 1'b1, 16'h0000, 0,            K_UNF,  16'hFFFF, 2'b10, 16'h1234};
        vecs[3] = '{1'b1, 1'b1, 16'hAAAA, 0,            K_DONE, 16'hFFFE, 2'b00, 16'h1234};
        vecs[4] = '{1'b1, 1'b0, 16'h5555, 2,            K_DONE, 16'hFFFD, 2'b00, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 16'h7777, WAIT_MAX,     K_TMO,  16'hFFFD, 2'b11, 16'h1234};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, WAIT_MAX - 1, K_DONE, 16'hFFFE, 2'b00, 16'h5555};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 1,            K_DONE, 16'hFFFF, 2'b00, 16'hAAAA};
        vecs[8] = '{1'b0, 1'b1, 16'h0000, WAIT_MAX,     K_UNF,  16'hFFFF, 2'b10, 16'hAAAA};
        vecs[9] = '{1'b1, 1'b0, 16'hBEEF, 1,            K_DONE, 16'hFFFE, 2'b00, 16'hAAAA};

        bus.req_push  = 1'b0;
        bus.req_pop   = 1'b0;
        bus.push_data = 16'h0000;
        #2;
        do_reset();

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].p, vecs[i].q, vecs[i].d, vecs[i].lat, 1'b0, ok, osp, ocode, opd);
            check("vec_kind",     int'(ok), int'(vecs[i].ek));
            check("vec_sp",       osp,      vecs[i].sp);
            check("vec_err_code", ocode,    vecs[i].code);
            check("vec_pop_data", opd,      vecs[i].pd);
        end

        // Randomised traffic with requests toggled while busy.
        for (int i = 0; i < 300; i++) begin
            int r;
            int lat;
            r   = $urandom_range(0, 9);
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WAIT_MAX + 2) : 0;
            run_op((r < 5) || (r == 9), r >= 5, 16'($urandom), lat, 1'b1, ok, osp, ocode, opd);
        end

        // Fill to the limit, overflow, then drain in LIFO order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            run_op(1'b1, 1'b0, 16'(i * 3 + 1), 0, 1'b0, ok, osp, ocode, opd);
        end
        check("full_sp", osp, 16'hFEFF);
        run_op(1'b1, 1'b0, 16'hDEAD, 0, 1'b0, ok, osp, ocode, opd);
        check("ovf_kind", int'(ok), int'(K_OVF));
        check("ovf_sp",   osp, 16'hFEFF);
        check("ovf_code", ocode, 2'b01);
        for (int i = 0; i < DEPTH; i++) begin
            run_op(1'b0, 1'b1, 16'h0000, i % 3, 1'b0, ok, osp, ocode, opd);
        end
        check("drain_last", opd, 16'h0001);
        check("drain_sp",   osp, STACK_TOP);

        // Reset in the middle of a stalled write.
        run_op(1'b1, 1'b0, 16'h0F0F, 0, 1'b0, ok, osp, ocode, opd);
        bus.req_push  = 1'b1;
        bus.push_data = 16'hCAFE;
        mem_lat       = 100;
        @(negedge clk);
        bus.req_push = 1'b0;
        @(negedge clk);
        check("write_stalled_we", bus.mem_we, 1);
        check("write_stalled_addr", bus.mem_addr, 16'hFFFE);
        #2;
        do_reset();
        run_op(1'b0, 1'b1, 16'h0000, 0, 1'b0, ok, osp, ocode, opd);
        check("post_reset_unf", int'(ok), int'(K_UNF));

        check("we_re_exclusive", both_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stack_ctrl
